dispatch_fifo_multi: RTL and testbench

- Multi-entry-per-cycle FIFO between decode/rename and issue_buff_ooo.
- Decode pushes up to PUSH_WIDTH micro-ops per cycle using a count handshake. The FIFO presents up to POP_WIDTH oldest entries to the issue buffer, which accepts a prefix of them using the same count handshake.
- Decouples decode bursts from issue-buffer back-pressure and preserves program order.

---
 rtl/dispatch_fifo_multi_pkg.sv | 12 +
 rtl/dispatch_fifo_multi_if.sv | 30 +++
 rtl/dispatch_fifo_multi_min_ct.sv | 12 +
 rtl/dispatch_fifo_multi.sv | 108 ++++++++++
 tb/tb_dispatch_fifo_multi.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/dispatch_fifo_multi_pkg.sv
// Shared constants and helpers for the decode-to-issue dispatch FIFO.
package dispatch_fifo_multi_pkg;

  localparam int DISP_DATA_WIDTH = 47;
  localparam int DISP_PUSH_WIDTH = 4;

  // Width of a count that must represent 0..n inclusive.
  function automatic int ct_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/dispatch_fifo_multi_if.sv
// Push and pop count handshakes of the dispatch FIFO.
interface dispatch_fifo_multi_if
  import dispatch_fifo_multi_pkg::*;
#(
  parameter int DATA_WIDTH = DISP_DATA_WIDTH,
  parameter int PUSH_WIDTH = DISP_PUSH_WIDTH,
  parameter int POP_WIDTH  = 4
);

  localparam int PUSH_CT_W = ct_width(PUSH_WIDTH);
  localparam int POP_CT_W  = ct_width(POP_WIDTH);

  logic [DATA_WIDTH*PUSH_WIDTH-1:0] in_data;
  logic [PUSH_CT_W-1:0]             in_valid_ct;
  logic [PUSH_CT_W-1:0]             in_ready_ct;
  logic [DATA_WIDTH*POP_WIDTH-1:0]  out_data;
  logic [POP_CT_W-1:0]              out_valid_ct;
  logic [POP_CT_W-1:0]              out_ready_ct;

  modport slave (
    input  in_data, in_valid_ct, out_ready_ct,
    output in_ready_ct, out_data, out_valid_ct
  );

  modport master (
    output in_data, in_valid_ct, out_ready_ct,
    input  in_ready_ct, out_data, out_valid_ct
  );

endinterface

// File: rtl/dispatch_fifo_multi_min_ct.sv
// Unsigned minimum of two count values.
module min_ct #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  assign o_y = (i_a < i_b) ? i_a : i_b;

endmodule

// File: rtl/dispatch_fifo_multi.sv
// Multi-entry-per-cycle in-order FIFO between decode/rename and the issue buffer.
module dispatch_fifo_multi
  import dispatch_fifo_multi_pkg::*;
#(
  parameter int DATA_WIDTH = DISP_DATA_WIDTH,
  parameter int PUSH_WIDTH = DISP_PUSH_WIDTH,
  parameter int POP_WIDTH  = 4,
  parameter int DEPTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  dispatch_fifo_multi_if.slave        bus,
  output logic [ct_width(DEPTH)-1:0]  count
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = ct_width(DEPTH);
  localparam int PUSH_CT_W = ct_width(PUSH_WIDTH);
  localparam int POP_CT_W  = ct_width(POP_WIDTH);

  localparam logic [CNT_W-1:0] PUSH_LIM  = CNT_W'(PUSH_WIDTH);
  localparam logic [CNT_W-1:0] POP_LIM   = CNT_W'(POP_WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_CT  = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [CNT_W-1:0]      w_space;
  logic [CNT_W-1:0]      w_ready_full;
  logic [CNT_W-1:0]      w_valid_full;
  logic [PUSH_CT_W-1:0]  w_ready;
  logic [PUSH_CT_W-1:0]  w_pushed;
  logic [POP_CT_W-1:0]   w_valid;
  logic [POP_CT_W-1:0]   w_popped;
  logic [DATA_WIDTH*POP_WIDTH-1:0] w_out_data;

  // Ready ignores any same-cycle pop so out_ready_ct never reaches in_ready_ct.
  assign w_space = DEPTH_CT - r_count;

  min_ct #(.W(CNT_W)) u_ready_min (
    .i_a (PUSH_LIM),
    .i_b (w_space),
    .o_y (w_ready_full)
  );
  assign w_ready = PUSH_CT_W'(w_ready_full);

  min_ct #(.W(PUSH_CT_W)) u_push_min (
    .i_a (bus.in_valid_ct),
    .i_b (w_ready),
    .o_y (w_pushed)
  );

  min_ct #(.W(CNT_W)) u_valid_min (
    .i_a (POP_LIM),
    .i_b (r_count),
    .o_y (w_valid_full)
  );
  assign w_valid = POP_CT_W'(w_valid_full);

  min_ct #(.W(POP_CT_W)) u_pop_min (
    .i_a (bus.out_ready_ct),
    .i_b (w_valid),
    .o_y (w_popped)
  );

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int unsigned k = 0; k < PUSH_WIDTH; k++) begin
        if (PUSH_CT_W'(k) < w_pushed)
          r_mem[r_wr_ptr + PTR_W'(k)] <= bus.in_data[DATA_WIDTH*k +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_pushed);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_popped);
      r_count  <= r_count + CNT_W'(w_pushed) - CNT_W'(w_popped);
    end
  end

  // Pointer arithmetic wraps modulo DEPTH, so reads straddling the end stay contiguous.
  always_comb begin
    w_out_data = '0;
    for (int unsigned k = 0; k < POP_WIDTH; k++) begin
      if (POP_CT_W'(k) < w_valid)
        w_out_data[DATA_WIDTH*k +: DATA_WIDTH] = r_mem[r_rd_ptr + PTR_W'(k)];
    end
  end

  assign bus.in_ready_ct  = w_ready;
  assign bus.out_valid_ct = w_valid;
  assign bus.out_data     = w_out_data;
  assign count            = r_count;

endmodule

// File: tb/tb_dispatch_fifo_multi.sv
// Scoreboard bench for dispatch_fifo_multi: queue model of stored micro-ops in program order.
module tb_dispatch_fifo_multi;
  import dispatch_fifo_multi_pkg::*;

  localparam int DW    = 47;
  localparam int PW    = 4;
  localparam int QW    = 4;
  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [3:0] count;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] sb [$];

  dispatch_fifo_multi_if #(.DATA_WIDTH(DW), .PUSH_WIDTH(PW), .POP_WIDTH(QW)) bus ();

  dispatch_fifo_multi #(
    .DATA_WIDTH (DW),
    .PUSH_WIDTH (PW),
    .POP_WIDTH  (QW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle: drive at negedge, compare pre-edge outputs with the model, update model at posedge.
  task automatic step(input int nv, input int nr, input bit do_flush);
    int            mcnt;
    int            ready;
    int            vld;
    int            pushed;
    int            popped;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    flush = do_flush;
    bus.in_valid_ct  = 3'(nv);
    bus.out_ready_ct = 3'(nr);
    for (int k = 0; k < PW; k++) begin
      d = DW'({$urandom, $urandom});
      bus.in_data[DW*k +: DW] = d;
    end
    #1;
    mcnt   = sb.size();
    ready  = imin(PW, DEPTH - mcnt);
    vld    = imin(QW, mcnt);
    pushed = imin(nv, ready);
    popped = imin(nr, vld);
    check_eq("count", 64'(count), 64'(mcnt));
    check_eq("in_ready_ct", 64'(bus.in_ready_ct), 64'(ready));
    check_eq("out_valid_ct", 64'(bus.out_valid_ct), 64'(vld));
    for (int k = 0; k < QW; k++) begin
      if (k < popped) begin
        exp_d = sb.pop_front();
        check_eq("pop_data", 64'(bus.out_data[DW*k +: DW]), 64'(exp_d));
      end else if (k < vld) begin
        check_eq("present_data", 64'(bus.out_data[DW*k +: DW]), 64'(sb[k-popped]));
      end else begin
        check_eq("idle_slot_zero", 64'(bus.out_data[DW*k +: DW]), 64'd0);
      end
    end
    for (int k = 0; k < pushed; k++)
      sb.push_back(bus.in_data[DW*k +: DW]);
    @(posedge clk);
    if (do_flush) sb.delete();
  endtask

  task automatic async_reset_midpush();
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid_ct  = 3'd4;
    bus.out_ready_ct = 3'd0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready_ct), 64'd4);
    check_eq("rst_out_valid", 64'(bus.out_valid_ct), 64'd0);
    check_eq("rst_out_data", 64'(bus.out_data == '0), 64'd1);
    sb.delete();
    bus.in_valid_ct = 3'd0;
    #1 rst = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_data = '0;
    bus.in_valid_ct = '0;
    bus.out_ready_ct = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    step(0, 0, 0);
    step(3, 0, 0);
    step(0, 0, 0);
    step(4, 0, 0);
    step(4, 0, 0);
    step(4, 0, 0);
    step(0, 2, 0);
    step(0, 0, 0);

    step(0, 4, 0);
    step(2, 0, 0);
    step(4, 0, 0);
    step(0, 4, 0);
    step(0, 4, 0);

    step(4, 0, 0);
    step(1, 0, 0);
    step(3, 4, 0);
    step(0, 0, 0);
    step(0, 7, 0);

    step(4, 0, 0);
    step(2, 0, 0);
    step(2, 0, 1);
    step(0, 0, 0);

    step(4, 0, 0);
    async_reset_midpush();
    step(0, 0, 0);

    for (int i = 0; i < 80; i++)
      step($urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 19) == 0));
    step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
